// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin arbiter that shares one UART_TX among N_REQ
//                byte-stream requesters, one packet per grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int CMD_PKT_LEN = 16,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                        uart_clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]            req_last,
    output logic [N_REQ-1:0]            ack,
    output logic [N_REQ-1:0]            grant,
    output logic                        tx_en,
    output logic [DATA_WIDTH-1:0]       tx_in,
    input  logic                        tx_done,
    output logic                        busy,
    output logic                        trunc,
    output logic                        timeout
);

    localparam int c_idx_w = $clog2(N_REQ);
    localparam int c_sum_w = c_idx_w + 1;
    localparam int c_cnt_w = $clog2(CMD_PKT_LEN + 1);
    localparam int c_wd_w  = $clog2(TIMEOUT_CYC);

    localparam logic [c_cnt_w-1:0] c_pkt_max  = c_cnt_w'(CMD_PKT_LEN);
    localparam logic [c_wd_w-1:0]  c_wd_last  = c_wd_w'(TIMEOUT_CYC - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(N_REQ - 1);
    localparam logic [c_sum_w-1:0] c_n_req    = c_sum_w'(N_REQ);
    localparam logic [N_REQ-1:0]   c_one      = N_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_idx_w-1:0]   r_rr_ptr;
    logic [c_idx_w-1:0]   r_owner;
    logic [c_cnt_w-1:0]   r_byte_cnt;
    logic [c_wd_w-1:0]    r_wd_cnt;
    logic                 r_last;

    logic [DATA_WIDTH-1:0] w_req_byte [N_REQ];
    logic                  w_win_found;
    logic [c_idx_w-1:0]    w_win_idx;
    logic [c_sum_w-1:0]    w_sum;
    logic [c_idx_w-1:0]    w_next_ptr;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_req_byte[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // First asserted request in the order rr_ptr, rr_ptr+1, ... modulo N_REQ
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_sum       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + c_sum_w'(k);
            if (w_sum >= c_n_req) begin
                w_sum = w_sum - c_n_req;
            end
            if (!w_win_found && req[w_sum[c_idx_w-1:0]]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_sum[c_idx_w-1:0];
            end
        end
    end

    assign w_next_ptr = (r_owner == c_idx_last) ? '0 : r_owner + 1'b1;

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_byte_cnt <= '0;
            r_wd_cnt   <= '0;
            r_last     <= 1'b0;
            ack        <= '0;
            grant      <= '0;
            tx_en      <= 1'b0;
            tx_in      <= '0;
            busy       <= 1'b0;
            trunc      <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            ack     <= '0;
            tx_en   <= 1'b0;
            trunc   <= 1'b0;
            timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_win_found) begin
                        grant   <= c_one << w_win_idx;
                        r_owner <= w_win_idx;
                        busy    <= 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tx_en      <= 1'b1;
                    tx_in      <= w_req_byte[r_owner];
                    ack        <= grant;
                    r_last     <= req_last[r_owner];
                    r_byte_cnt <= r_byte_cnt + 1'b1;
                    r_wd_cnt   <= '0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        r_state <= ST_GAP;
                    end else if (r_wd_cnt == c_wd_last) begin
                        timeout    <= 1'b1;
                        grant      <= '0;
                        r_byte_cnt <= '0;
                        r_rr_ptr   <= w_next_ptr;
                        busy       <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    // The owner keeps the transmitter only if its next byte is already waiting
                    if (req[r_owner] && !r_last && (r_byte_cnt < c_pkt_max)) begin
                        r_state <= ST_LOAD;
                    end else begin
                        trunc      <= (r_byte_cnt == c_pkt_max) && !r_last;
                        grant      <= '0;
                        r_byte_cnt <= '0;
                        r_rr_ptr   <= w_next_ptr;
                        busy       <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Directed self-checking bench for uart_tx_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    logic        uart_clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        tx_en;
    logic [7:0]  tx_in;
    logic        tx_done;
    logic        busy;
    logic        trunc;
    logic        timeout;

    uart_tx_arbiter #(
        .N_REQ       (4),
        .DATA_WIDTH  (8),
        .CMD_PKT_LEN (16),
        .TIMEOUT_CYC (15)
    ) dut (
        .uart_clk (uart_clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .ack      (ack),
        .grant    (grant),
        .tx_en    (tx_en),
        .tx_in    (tx_in),
        .tx_done  (tx_done),
        .busy     (busy),
        .trunc    (trunc),
        .timeout  (timeout)
    );

    always #5 uart_clk = ~uart_clk;

    typedef struct packed {
        logic       last;
        logic [7:0] d;
    } item_t;

    item_t      q [4][$];
    int         cyc;
    int         errors;
    int         checks;
    int         ev_t [$];
    logic [7:0] ev_d [$];
    logic [3:0] ev_g [$];
    logic [3:0] ack_log [$];
    int         n_trunc;
    int         n_to;
    int         to_cyc;
    logic [3:0] grant_at_to;
    logic       busy_at_to;
    int         dcnt;
    bit         tie0;

    task automatic push_item(input int i, input logic last, input logic [7:0] d);
        item_t it;
        it.last = last;
        it.d    = d;
        q[i].push_back(it);
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (q[i].size() != 0) begin
                req[i]            = 1'b1;
                req_data[i*8 +: 8] = q[i][0].d;
                req_last[i]       = q[i][0].last;
            end else begin
                req[i]            = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
    endtask

    task automatic clear_logs();
        ev_t.delete();
        ev_d.delete();
        ev_g.delete();
        ack_log.delete();
        n_trunc = 0;
        n_to    = 0;
    endtask

    // One cycle: sample outputs, model UART_TX done timing, advance requesters
    task automatic step();
        @(negedge uart_clk);
        cyc++;
        if (tx_en) begin
            ev_t.push_back(cyc);
            ev_d.push_back(tx_in);
            ev_g.push_back(grant);
        end
        if (ack != 4'b0000) ack_log.push_back(ack);
        if (trunc) n_trunc++;
        if (timeout) begin
            n_to++;
            to_cyc      = cyc;
            grant_at_to = grant;
            busy_at_to  = busy;
        end
        tx_done = 1'b0;
        if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) tx_done = 1'b1;
        end
        if (tx_en && !tie0) dcnt = 10;
        for (int i = 0; i < 4; i++) begin
            if (ack[i] && q[i].size() != 0) void'(q[i].pop_front());
        end
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        dcnt    = 0;
        tx_done = 1'b0;
        for (int i = 0; i < 4; i++) q[i].delete();
        drive();
        run(2);
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic test_reset();
        run(2);
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %0h expected 0", ack); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %0h expected 0", grant); end
        checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en: got %0b expected 0", tx_en); end
        checks++; if (tx_in !== 8'h00) begin errors++; $display("FAIL reset_tx_in: got %0h expected 0", tx_in); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (trunc !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL reset_pulses: got trunc=%0b timeout=%0b expected 0 0", trunc, timeout); end
        rst_n = 1'b1;
        clear_logs();
        run(5);
        checks++; if (ev_t.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL idle_no_req: got %0d tx_en busy=%0b expected 0 0", ev_t.size(), busy); end
    endtask

    task automatic test_single_packet();
        int t0;
        logic [7:0] exp_d [3];
        exp_d[0] = 8'hA5; exp_d[1] = 8'h3C; exp_d[2] = 8'h81;
        clear_logs();
        push_item(1, 1'b0, 8'hA5);
        push_item(1, 1'b0, 8'h3C);
        push_item(1, 1'b1, 8'h81);
        drive();
        t0 = cyc;
        run(50);
        checks++; if (ev_t.size() != 3) begin errors++; $display("FAIL single_count: got %0d expected 3", ev_t.size()); end
        for (int i = 0; i < 3; i++) begin
            int      t_got;
            logic [7:0] d_got;
            logic [3:0] g_got;
            t_got = (i < ev_t.size()) ? ev_t[i] : -1;
            d_got = (i < ev_d.size()) ? ev_d[i] : 8'hxx;
            g_got = (i < ev_g.size()) ? ev_g[i] : 4'hx;
            checks++; if (t_got != t0 + 2 + 13*i) begin errors++; $display("FAIL single_time[%0d]: got %0d expected %0d", i, t_got - t0, 2 + 13*i); end
            checks++; if (d_got !== exp_d[i]) begin errors++; $display("FAIL single_data[%0d]: got %0h expected %0h", i, d_got, exp_d[i]); end
            checks++; if (g_got !== 4'b0010) begin errors++; $display("FAIL single_grant[%0d]: got %0h expected 2", i, g_got); end
        end
        checks++; if (ack_log.size() != 3 || ack_log[0] !== 4'b0010 || ack_log[2] !== 4'b0010) begin errors++; $display("FAIL single_ack: got %0d pulses expected 3 on req1", ack_log.size()); end
        checks++; if (n_trunc != 0) begin errors++; $display("FAIL single_trunc: got %0d expected 0", n_trunc); end
        checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_release: got grant=%0h busy=%0b expected 0 0", grant, busy); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [5];
        logic [3:0] exp_g [5];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44; exp_d[4] = 8'h15;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        do_reset();
        push_item(0, 1'b1, 8'h11);
        push_item(0, 1'b1, 8'h15);
        push_item(1, 1'b1, 8'h22);
        push_item(2, 1'b1, 8'h33);
        push_item(3, 1'b1, 8'h44);
        drive();
        run(80);
        checks++; if (ev_t.size() != 5) begin errors++; $display("FAIL rr_count: got %0d expected 5", ev_t.size()); end
        for (int i = 0; i < 5; i++) begin
            logic [7:0] d_got;
            logic [3:0] g_got;
            d_got = (i < ev_d.size()) ? ev_d[i] : 8'hxx;
            g_got = (i < ev_g.size()) ? ev_g[i] : 4'hx;
            checks++; if (d_got !== exp_d[i] || g_got !== exp_g[i]) begin errors++; $display("FAIL rr_order[%0d]: got grant=%0h data=%0h expected grant=%0h data=%0h", i, g_got, d_got, exp_g[i], exp_d[i]); end
        end
        checks++; if (ev_t.size() < 2 || ev_t[1] - ev_t[0] != 14) begin errors++; $display("FAIL rr_spacing: got %0d expected 14", (ev_t.size() < 2) ? -1 : ev_t[1] - ev_t[0]); end
    endtask

    task automatic test_truncation();
        int n_ack2;
        clear_logs();
        for (int k = 0; k < 20; k++) push_item(2, 1'b0, 8'(8'h50 + k));
        push_item(3, 1'b1, 8'hC3);
        drive();
        run(330);
        checks++; if (ev_t.size() != 21) begin errors++; $display("FAIL trunc_count: got %0d expected 21", ev_t.size()); end
        for (int i = 0; i < 21; i++) begin
            logic [7:0] e_d;
            logic [3:0] e_g;
            logic [7:0] d_got;
            logic [3:0] g_got;
            if (i < 16) begin e_d = 8'(8'h50 + i); e_g = 4'b0100; end
            else if (i == 16) begin e_d = 8'hC3; e_g = 4'b1000; end
            else begin e_d = 8'(8'h50 + i - 1); e_g = 4'b0100; end
            d_got = (i < ev_d.size()) ? ev_d[i] : 8'hxx;
            g_got = (i < ev_g.size()) ? ev_g[i] : 4'hx;
            checks++; if (d_got !== e_d || g_got !== e_g) begin errors++; $display("FAIL trunc_seq[%0d]: got grant=%0h data=%0h expected grant=%0h data=%0h", i, g_got, d_got, e_g, e_d); end
        end
        checks++; if (n_trunc != 1) begin errors++; $display("FAIL trunc_pulses: got %0d expected 1", n_trunc); end
        n_ack2 = 0;
        foreach (ack_log[i]) if (ack_log[i] === 4'b0100) n_ack2++;
        checks++; if (n_ack2 != 20) begin errors++; $display("FAIL trunc_acks: got %0d expected 20", n_ack2); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL trunc_idle: got busy=%0b expected 0", busy); end
    endtask

    task automatic test_timeout();
        int t0;
        clear_logs();
        tie0 = 1'b1;
        push_item(0, 1'b1, 8'h99);
        drive();
        t0 = cyc;
        run(25);
        checks++; if (n_to != 1) begin errors++; $display("FAIL to_pulses: got %0d expected 1", n_to); end
        checks++; if (ev_t.size() != 1 || to_cyc - ev_t[0] != 15) begin errors++; $display("FAIL to_delay: got %0d expected 15", (ev_t.size() == 0) ? -1 : to_cyc - ev_t[0]); end
        checks++; if (grant_at_to !== 4'b0000 || busy_at_to !== 1'b0) begin errors++; $display("FAIL to_release: got grant=%0h busy=%0b expected 0 0", grant_at_to, busy_at_to); end
        tie0 = 1'b0;
        clear_logs();
        push_item(1, 1'b1, 8'h12);
        drive();
        t0 = cyc;
        run(20);
        checks++; if (ev_t.size() != 1 || ev_t[0] != t0 + 2 || ev_d[0] !== 8'h12 || ev_g[0] !== 4'b0010) begin errors++; $display("FAIL to_next_served: got %0d tx_en expected 1 of data 12 on req1", ev_t.size()); end
    endtask

    task automatic test_reset_mid();
        int guard;
        clear_logs();
        push_item(3, 1'b0, 8'hD0);
        push_item(3, 1'b0, 8'hD1);
        push_item(3, 1'b1, 8'hD2);
        drive();
        guard = 0;
        while (ev_t.size() < 2 && guard < 40) begin
            step();
            guard++;
        end
        checks++; if (ev_t.size() != 2) begin errors++; $display("FAIL rst_mid_reach: got %0d tx_en expected 2", ev_t.size()); end
        run(3);
        checks++; if (busy !== 1'b1 || grant !== 4'b1000) begin errors++; $display("FAIL rst_mid_pre: got busy=%0b grant=%0h expected 1 8", busy, grant); end
        rst_n = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000 || busy !== 1'b0 || tx_in !== 8'h00) begin errors++; $display("FAIL rst_mid_async: got grant=%0h busy=%0b tx_in=%0h expected 0 0 0", grant, busy, tx_in); end
        checks++; if (ack !== 4'b0000 || tx_en !== 1'b0 || trunc !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL rst_mid_pulses: got ack=%0h tx_en=%0b expected 0 0", ack, tx_en); end
        dcnt    = 0;
        tx_done = 1'b0;
        step();
        rst_n = 1'b1;
        clear_logs();
        push_item(1, 1'b1, 8'hE1);
        drive();
        run(40);
        checks++; if (ev_t.size() != 2) begin errors++; $display("FAIL rst_mid_count: got %0d expected 2", ev_t.size()); end
        checks++; if (ev_g.size() < 2 || ev_g[0] !== 4'b0010 || ev_d[0] !== 8'hE1 || ev_g[1] !== 4'b1000 || ev_d[1] !== 8'hD2) begin errors++; $display("FAIL rst_mid_order: got first grant=%0h expected 2 then 8", (ev_g.size() == 0) ? 4'hx : ev_g[0]); end
    endtask

    task automatic test_drop();
        int t0;
        clear_logs();
        push_item(0, 1'b0, 8'h61);
        push_item(0, 1'b0, 8'h62);
        drive();
        run(40);
        checks++; if (ev_t.size() != 2 || ev_d[0] !== 8'h61 || ev_d[1] !== 8'h62) begin errors++; $display("FAIL drop_bytes: got %0d tx_en expected 2", ev_t.size()); end
        checks++; if (n_trunc != 0) begin errors++; $display("FAIL drop_trunc: got %0d expected 0", n_trunc); end
        checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL drop_release: got grant=%0h busy=%0b expected 0 0", grant, busy); end
        run(10);
        checks++; if (ev_t.size() != 2) begin errors++; $display("FAIL drop_quiet: got %0d tx_en expected 2", ev_t.size()); end
        push_item(0, 1'b1, 8'h63);
        drive();
        t0 = cyc;
        run(20);
        checks++; if (ev_t.size() != 3 || ev_t[2] != t0 + 2 || ev_g[2] !== 4'b0001 || ev_d[2] !== 8'h63) begin errors++; $display("FAIL drop_regrant: got %0d tx_en expected 3", ev_t.size()); end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        cyc      = 0;
        dcnt     = 0;
        tie0     = 1'b0;
        tx_done  = 1'b0;
        rst_n    = 1'b0;
        req      = '0;
        req_data = '0;
        req_last = '0;
        clear_logs();
        drive();
        test_reset();
        test_single_packet();
        test_round_robin();
        test_truncation();
        test_timeout();
        test_reset_mid();
        test_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
